// File: rtl/irrigation_scheduler.sv
// Irrigation scheduler: duration config, start latching and the enable/done handshake with the phase sequencer.
// Define IRRIGATION_SCHEDULER_PHASE_CHECK_EN to build the per-run phase-length check (error_code 3).
module irrigation_scheduler #(
  parameter int               DUR_W  = 8,
  parameter int               CNT_W  = 12,
  parameter int               MARGIN = 8,
  parameter logic [DUR_W-1:0] D1_RST = DUR_W'(10),
  parameter logic [DUR_W-1:0] D2_RST = DUR_W'(5),
  parameter logic [DUR_W-1:0] D3_RST = DUR_W'(10)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [DUR_W-1:0] cfg_data,
  input  logic             clear_error,
  input  logic             seq_done,
  input  logic             seq_irrigation_active,
  input  logic             seq_ventilation_active,
  output logic             seq_enable,
  output logic [DUR_W-1:0] state1_duration,
  output logic [DUR_W-1:0] state2_duration,
  output logic [DUR_W-1:0] state3_duration,
  output logic             busy,
  output logic             cycle_done,
  output logic [7:0]       cycle_count,
  output logic [1:0]       error_code
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT_DONE, S_RELEASE, S_WAIT_IDLE, S_FAULT
  } state_t;

  localparam logic [1:0] ERR_ZERO     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_MISMATCH = 2'd3;

  state_t           state, next_state;
  logic [DUR_W-1:0] cfg_d1, cfg_d2, cfg_d3;
  logic             pending;
  logic [CNT_W-1:0] watchdog, watchdog_inc, limit;
  logic [1:0]       new_err;
  logic             req, cfg_ok, timeout, phase_bad, launch;
  logic             seq_enable_d, busy_d, cycle_done_d;

  assign req         = start_req | pending;
  assign cfg_ok      = (cfg_d1 != '0) && (cfg_d2 != '0) && (cfg_d3 != '0);
  assign limit       = CNT_W'(state1_duration) + CNT_W'(state2_duration)
                     + CNT_W'(state3_duration) + CNT_W'(MARGIN);
  assign watchdog_inc = watchdog + CNT_W'(1);
  assign timeout     = (watchdog_inc >= limit);
  assign launch      = (state == S_IDLE) && (next_state == S_ARM);

`ifdef IRRIGATION_SCHEDULER_PHASE_CHECK_EN
  logic [CNT_W-1:0] irr_cnt, ven_cnt;

  // Both counters are bounded by the watchdog limit, so they cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      irr_cnt <= '0;
      ven_cnt <= '0;
    end else if (state == S_ARM) begin
      irr_cnt <= '0;
      ven_cnt <= '0;
    end else if (state == S_WAIT_DONE) begin
      if (seq_irrigation_active)  irr_cnt <= irr_cnt + CNT_W'(1);
      if (seq_ventilation_active) ven_cnt <= ven_cnt + CNT_W'(1);
    end
  end

  assign phase_bad = (irr_cnt != CNT_W'(state1_duration)) ||
                     (ven_cnt != CNT_W'(state3_duration));
`else
  logic unused_phase_inputs;
  assign unused_phase_inputs = seq_irrigation_active ^ seq_ventilation_active;
  assign phase_bad = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: defaults first so every path assigns every output and no latch is inferred.
  always_comb begin
    next_state = state;
    new_err    = 2'd0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (cfg_ok) begin
            next_state = S_ARM;
          end else begin
            next_state = S_FAULT;
            new_err    = ERR_ZERO;
          end
        end
      end
      S_ARM:       next_state = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done arriving on the timeout cycle still counts as a good run.
        if (seq_done) begin
          next_state = S_RELEASE;
        end else if (timeout) begin
          next_state = S_FAULT;
          new_err    = ERR_TIMEOUT;
        end
      end
      S_RELEASE:   next_state = S_WAIT_IDLE;
      S_WAIT_IDLE: begin
        if (!seq_done) begin
          next_state = S_IDLE;
          if (phase_bad) new_err = ERR_MISMATCH;
        end
      end
      S_FAULT:     if (clear_error && !seq_done) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered below.
  always_comb begin
    seq_enable_d = (next_state == S_WAIT_DONE);
    busy_d       = (next_state != S_IDLE);
    cycle_done_d = (state == S_WAIT_IDLE) && (next_state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_enable      <= 1'b0;
      busy            <= 1'b0;
      cycle_done      <= 1'b0;
      cycle_count     <= '0;
      error_code      <= '0;
      pending         <= 1'b0;
      watchdog        <= '0;
      cfg_d1          <= D1_RST;
      cfg_d2          <= D2_RST;
      cfg_d3          <= D3_RST;
      state1_duration <= D1_RST;
      state2_duration <= D2_RST;
      state3_duration <= D3_RST;
    end else begin
      seq_enable <= seq_enable_d;
      busy       <= busy_d;
      cycle_done <= cycle_done_d;

      if (cycle_done_d && (cycle_count != 8'hFF)) cycle_count <= cycle_count + 8'd1;

      if (new_err != 2'd0)
        error_code <= new_err;
      else if (clear_error && ((state != S_FAULT) || !seq_done))
        error_code <= '0;

      if ((state == S_FAULT) || (next_state == S_FAULT) || launch)
        pending <= 1'b0;
      else if (start_req)
        pending <= 1'b1;

      if (state == S_ARM)            watchdog <= '0;
      else if (state == S_WAIT_DONE) watchdog <= watchdog_inc;

      if (cfg_we) begin
        case (cfg_sel)
          2'd0:    cfg_d1 <= cfg_data;
          2'd1:    cfg_d2 <= cfg_data;
          2'd2:    cfg_d3 <= cfg_data;
          default: ;
        endcase
      end

      // Shadows only move at launch, so a run never sees a mid-run config write.
      if (launch) begin
        state1_duration <= cfg_d1;
        state2_duration <= cfg_d2;
        state3_duration <= cfg_d3;
      end
    end
  end

endmodule

// File: tb/tb_irrigation_scheduler.sv
// Self-checking bench for irrigation_scheduler with a behavioural phase-sequencer model.
module tb_irrigation_scheduler;
  localparam int MARGIN = 8;

  logic       clk = 1'b0;
  logic       reset, start_req, cfg_we, clear_error;
  logic [1:0] cfg_sel;
  logic [7:0] cfg_data;
  logic       seq_done, seq_irrigation_active, seq_ventilation_active;
  logic       seq_enable, busy, cycle_done;
  logic [7:0] state1_duration, state2_duration, state3_duration, cycle_count;
  logic [1:0] error_code;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;

  // Sequencer model: counts cycles of enable, phases laid out back to back.
  int m_cnt = 0;
  int irr_len, gap_end, total;
  bit hang = 1'b0;
  bit irr_short = 1'b0;

  always #5 clk = ~clk;

  irrigation_scheduler dut (
    .clk(clk), .reset(reset), .start_req(start_req), .cfg_we(cfg_we),
    .cfg_sel(cfg_sel), .cfg_data(cfg_data), .clear_error(clear_error),
    .seq_done(seq_done), .seq_irrigation_active(seq_irrigation_active),
    .seq_ventilation_active(seq_ventilation_active), .seq_enable(seq_enable),
    .state1_duration(state1_duration), .state2_duration(state2_duration),
    .state3_duration(state3_duration), .busy(busy), .cycle_done(cycle_done),
    .cycle_count(cycle_count), .error_code(error_code)
  );

  always @(posedge clk) begin
    if (seq_enable !== 1'b1) m_cnt <= 0;
    else if (m_cnt < 4000)   m_cnt <= m_cnt + 1;
  end

  always_comb begin
    irr_len = int'(state1_duration) - (irr_short ? 1 : 0);
    gap_end = int'(state1_duration) + int'(state2_duration);
    total   = gap_end + int'(state3_duration);
    seq_irrigation_active  = (m_cnt >= 1) && (m_cnt <= irr_len);
    seq_ventilation_active = (m_cnt > gap_end) && (m_cnt <= total);
    seq_done               = !hang && (m_cnt > total);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [7:0] data);
    cfg_we = 1'b1; cfg_sel = sel; cfg_data = data;
    tick();
    cfg_we = 1'b0;
  endtask

  // Issues one start pulse and follows the run until the scheduler is idle again.
  task automatic run_cycle(output int en_cyc, output int dones, output int lat, output bit to);
    int t;
    en_cyc = 0; dones = 0; lat = -1; to = 1'b1; t = 0;
    start_req = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick(); t++;
      start_req = 1'b0;
      if (seq_enable) en_cyc++;
      if (cycle_done) begin dones++; if (lat < 0) lat = t; end
      if (!busy) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start_req = 1'b0; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; clear_error = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    exp_count = 0;
    checks++; if (seq_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got %0b exp 0", seq_enable); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (cycle_done !== 1'b0) begin errors++; $display("FAIL reset_cycle_done got %0b exp 0", cycle_done); end
    checks++; if (cycle_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", cycle_count); end
    checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL reset_error got %0d exp 0", error_code); end
    checks++;
    if ({state1_duration, state2_duration, state3_duration} !== {8'd10, 8'd5, 8'd10}) begin
      errors++;
      $display("FAIL reset_durations got %0d/%0d/%0d exp 10/5/10", state1_duration, state2_duration, state3_duration);
    end
  endtask

  task automatic test_default_run();
    int en, dn, lat, s;
    bit to;
    s = 10 + 5 + 10;
    run_cycle(en, dn, lat, to);
    exp_count++;
    checks++; if (to) begin errors++; $display("FAIL default_run_timeout got stuck busy exp idle"); end
    checks++; if (en < s + 1 || en > s + 3) begin errors++; $display("FAIL default_enable_len got %0d exp %0d+-1", en, s + 2); end
    checks++; if (dn != 1) begin errors++; $display("FAIL default_done_pulses got %0d exp 1", dn); end
    checks++; if (lat < s + 5 || lat > s + 7) begin errors++; $display("FAIL default_latency got %0d exp %0d+-1", lat, s + 6); end
    checks++; if (cycle_count !== 8'(exp_count)) begin errors++; $display("FAIL default_count got %0d exp %0d", cycle_count, exp_count); end
    checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL default_error got %0d exp 0", error_code); end
  endtask

  task automatic test_zero_duration();
    cfg_write(2'd1, 8'd0);
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_busy got %0b exp 1", busy); end
    checks++; if (error_code !== 2'd1) begin errors++; $display("FAIL zero_error got %0d exp 1", error_code); end
    repeat (3) tick();
    checks++; if (seq_enable !== 1'b0) begin errors++; $display("FAIL zero_enable got %0b exp 0", seq_enable); end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_clear_busy got %0b exp 0", busy); end
    checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL zero_clear_error got %0d exp 0", error_code); end
    cfg_write(2'd1, 8'd5);
  endtask

  task automatic test_timeout();
    int en;
    bit to;
    en = 0; to = 1'b1;
    hang = 1'b1;
    start_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      start_req = 1'b0;
      if (seq_enable) en++;
      if (error_code != 2'd0) begin to = 1'b0; break; end
    end
    checks++; if (to) begin errors++; $display("FAIL timeout_never got no fault exp fault"); end
    checks++; if (en != 25 + MARGIN) begin errors++; $display("FAIL timeout_wait_cycles got %0d exp %0d", en, 25 + MARGIN); end
    checks++; if (error_code !== 2'd2) begin errors++; $display("FAIL timeout_error got %0d exp 2", error_code); end
    checks++; if (seq_enable !== 1'b0) begin errors++; $display("FAIL timeout_enable got %0b exp 0", seq_enable); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy got %0b exp 1", busy); end
    // A request seen while faulted must be dropped, not replayed after the clear.
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    hang = 1'b0;
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL timeout_clear_error got %0d exp 0", error_code); end
    en = 0;
    for (int i = 0; i < 6; i++) begin tick(); if (busy) en++; end
    checks++; if (en != 0) begin errors++; $display("FAIL fault_request_dropped got %0d busy cycles exp 0", en); end
  endtask

  task automatic test_phase_mismatch();
    int en, dn, lat;
    bit to;
    logic [1:0] exp_err;
`ifdef IRRIGATION_SCHEDULER_PHASE_CHECK_EN
    exp_err = 2'd3;
`else
    exp_err = 2'd0;
`endif
    irr_short = 1'b1;
    run_cycle(en, dn, lat, to);
    irr_short = 1'b0;
    exp_count++;
    checks++; if (dn != 1) begin errors++; $display("FAIL mismatch_done got %0d exp 1", dn); end
    checks++; if (error_code !== exp_err) begin errors++; $display("FAIL mismatch_error got %0d exp %0d", error_code, exp_err); end
    checks++; if (cycle_count !== 8'(exp_count)) begin errors++; $display("FAIL mismatch_count got %0d exp %0d", cycle_count, exp_count); end
    clear_error = 1'b1;
    tick();
    clear_error = 1'b0;
    checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL idle_clear got %0d exp 0", error_code); end
  endtask

  task automatic test_back_to_back();
    int dn, extra;
    bit seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = seq_enable; end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_enable got 0 exp 1"); end
    for (int k = 0; k < 3; k++) begin
      start_req = 1'b1; tick(); start_req = 1'b0; tick();
    end
    cfg_write(2'd2, 8'd20);
    checks++; if (state3_duration !== 8'd10) begin errors++; $display("FAIL b2b_run1_d3 got %0d exp 10", state3_duration); end
    dn = 0;
    for (int i = 0; i < 100 && dn == 0; i++) begin tick(); if (cycle_done) dn++; end
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin tick(); seen = seq_enable; end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_second_enable got 0 exp 1"); end
    checks++; if (state3_duration !== 8'd20) begin errors++; $display("FAIL b2b_run2_d3 got %0d exp 20", state3_duration); end
    for (int i = 0; i < 100 && dn == 1; i++) begin tick(); if (cycle_done) dn++; end
    extra = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (busy || cycle_done) extra++; end
    exp_count = 2;
    checks++; if (dn != 2) begin errors++; $display("FAIL b2b_done_pulses got %0d exp 2", dn); end
    checks++; if (extra != 0) begin errors++; $display("FAIL b2b_extra_run got %0d busy cycles exp 0", extra); end
    checks++; if (cycle_count !== 8'd2) begin errors++; $display("FAIL b2b_count got %0d exp 2", cycle_count); end
    cfg_write(2'd2, 8'd10);
  endtask

  task automatic test_reset_mid_run();
    int dn;
    start_req = 1'b1;
    tick();
    start_req = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_count = 0;
    checks++; if (seq_enable !== 1'b0) begin errors++; $display("FAIL midreset_enable got %0b exp 0", seq_enable); end
    checks++; if (cycle_count !== 8'd0) begin errors++; $display("FAIL midreset_count got %0d exp 0", cycle_count); end
    dn = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (cycle_done || busy) dn++; end
    checks++; if (dn != 0) begin errors++; $display("FAIL midreset_activity got %0d cycles exp 0", dn); end
  endtask

  task automatic test_random_runs();
    int en, dn, lat, s;
    bit to;
    logic [7:0] d1, d2, d3;
    for (int n = 0; n < 5; n++) begin
      d1 = 8'($urandom_range(1, 12));
      d2 = 8'($urandom_range(1, 12));
      d3 = 8'($urandom_range(1, 12));
      s = int'(d1) + int'(d2) + int'(d3);
      cfg_write(2'd0, d1);
      cfg_write(2'd1, d2);
      cfg_write(2'd2, d3);
      cfg_write(2'd3, 8'($urandom_range(0, 255)));
      run_cycle(en, dn, lat, to);
      if (exp_count < 255) exp_count++;
      checks++; if (dn != 1 || to) begin errors++; $display("FAIL rand%0d_done got %0d exp 1", n, dn); end
      checks++; if (en < s + 1 || en > s + 3) begin errors++; $display("FAIL rand%0d_enable got %0d exp %0d+-1", n, en, s + 2); end
      checks++; if (lat < s + 5 || lat > s + 7) begin errors++; $display("FAIL rand%0d_latency got %0d exp %0d+-1", n, lat, s + 6); end
      checks++;
      if ({state1_duration, state2_duration, state3_duration} !== {d1, d2, d3}) begin
        errors++;
        $display("FAIL rand%0d_shadow got %0d/%0d/%0d exp %0d/%0d/%0d", n,
                 state1_duration, state2_duration, state3_duration, d1, d2, d3);
      end
      checks++; if (error_code !== 2'd0) begin errors++; $display("FAIL rand%0d_error got %0d exp 0", n, error_code); end
      checks++; if (cycle_count !== 8'(exp_count)) begin errors++; $display("FAIL rand%0d_count got %0d exp %0d", n, cycle_count, exp_count); end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_zero_duration();
    test_timeout();
    test_phase_mismatch();
    test_back_to_back();
    test_reset_mid_run();
    test_random_runs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irrigation_scheduler.md
Name: irrigation_scheduler

Overview:
- Initiator for the greenhouse irrigation/ventilation phase sequencer. It drives the sequencer's enable and three phase-duration inputs, and consumes its done, irrigation_active and ventilation_active outputs.
- Holds a programmable duration config, latches start requests, and runs the enable/done handshake once per cycle.
- Checks each run for a timeout and for wrong phase lengths, and keeps a completed-cycle count for the control plane.

Parameters:
- DUR_W, 8, width of each phase duration; matches the sequencer's duration inputs.
- CNT_W, 12, width of the watchdog and phase-measurement counters; must hold 3*(2^DUR_W-1)+MARGIN.
- MARGIN, 8, extra cycles allowed beyond d1+d2+d3 before timeout.
- D1_RST, 8'd10; D2_RST, 8'd5; D3_RST, 8'd10: reset values of the duration config registers.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start_req  in  1  request one irrigation cycle (single-cycle pulse or level).
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  config target: 0=d1, 1=d2, 2=d3; 3 is ignored.
- cfg_data  in  DUR_W  config write data.
- clear_error  in  1  clears the error code and leaves FAULT.
- seq_done  in  1  from sequencer done.
- seq_irrigation_active  in  1  from sequencer.
- seq_ventilation_active  in  1  from sequencer.
- seq_enable  out  1  to sequencer enable.
- state1_duration, state2_duration, state3_duration  out  DUR_W each  shadow durations sent to the sequencer.
- busy  out  1  high in any state other than IDLE.
- cycle_done  out  1  one-cycle pulse when a run completes.
- cycle_count  out  8  number of completed runs, saturating at 255.
- error_code  out  2  sticky: 0=none, 1=zero duration, 2=timeout, 3=phase mismatch.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on port reset.
- Values on reset:
  - Config registers load D1_RST, D2_RST, D3_RST; the shadow outputs take the same values.
  - seq_enable=0, busy=0, cycle_done=0, cycle_count=0, error_code=0, pending=0, state=IDLE.
- Reset mid-run drops seq_enable on the next edge. The sequencer then sees enable low and returns to its idle state on its own.
- Config writes take effect one cycle after cfg_we and are accepted in any state. The shadow outputs copy the config only on the IDLE->ARM transition, so writes during a run never affect that run.
- pending: set by start_req in any state except FAULT; cleared on IDLE->ARM. It is one deep, so extra requests during a run merge into one.
- State machine, all outputs registered:
  - IDLE: if (start_req|pending) and all three config values are nonzero -> ARM, latching the shadows. If the request arrives while any config value is 0 -> FAULT with error_code=1; the sequencer cannot run a zero-length phase.
  - ARM: seq_enable<=1, clear the watchdog and phase counters -> WAIT_DONE.
  - WAIT_DONE: seq_enable=1.
    - The watchdog increments every cycle.
    - irr_cnt increments on each cycle with seq_irrigation_active=1; ven_cnt does the same for seq_ventilation_active.
    - seq_done=1 -> RELEASE.
    - If the watchdog reaches d1+d2+d3+MARGIN (computed at CNT_W width, no overflow) first -> FAULT with error_code=2.
  - RELEASE: seq_enable<=0 -> WAIT_IDLE.
  - WAIT_IDLE: wait for seq_done=0.
    - Then pulse cycle_done and increment cycle_count (saturating), then go to IDLE.
    - Phase check (only when PHASE_CHECK_EN is defined): if irr_cnt!=d1 or ven_cnt!=d3, set error_code=3 but still complete the run.
  - FAULT: seq_enable=0, busy=1, pending cleared and start_req ignored. Leave to IDLE only when clear_error=1 and seq_done=0; error_code clears on that same edge.
- Expected handshake timing: with enable first high at edge t, irrigation_active is high for exactly d1 cycles and ventilation_active for exactly d3 cycles. seq_done rises d1+d2+d3+1 cycles after t. End-to-end latency from start_req to cycle_done is d1+d2+d3+6 cycles (±1).
- Priority within one cycle:
  - A timeout and seq_done in the same cycle: seq_done wins.
  - clear_error while not in FAULT clears a code left by a completed run (code 3).
  - A new nonzero error code overwrites the current one.

Optional Feature:
- Macro: IRRIGATION_SCHEDULER_PHASE_CHECK_EN.
- Defined: irr_cnt and ven_cnt are implemented, and a wrong phase length sets error_code=3 at WAIT_IDLE.
- Undefined: the counters are removed and error_code never takes the value 3.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults (10/5/10), one start_req pulse -> seq_enable high for 27±1 cycles, exactly one cycle_done, cycle_count=1, error_code=0.
- Write cfg_sel=1 data=0, then start_req -> next cycle busy=1, error_code=1, seq_enable stays 0. clear_error -> IDLE, error_code=0.
- seq_done held 0 by the sequencer model -> FAULT after exactly 33 WAIT_DONE cycles, error_code=2, seq_enable=0.
- With PHASE_CHECK_EN, model drives irrigation_active for 9 cycles with d1=10 -> cycle_done still pulses and error_code=3. Without the macro the same stimulus gives error_code=0.
- 3 start_req pulses during a run, plus cfg write d3=20 -> exactly one extra run follows; state3_duration=10 during the first run and 20 during the second; cycle_count=2.
- Assert reset in WAIT_DONE -> seq_enable=0 and cycle_count=0 next edge, no cycle_done pulse.
